// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b datapath types and fetch-unit helpers.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [3:0]  lc3b_opcode;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2
    } lc3b_fetch_state;

    // Instructions are 16-bit words, so the PC steps by two bytes.
    localparam lc3b_word PC_STEP = 16'd2;

    // Instruction addresses are always even; bit 0 of any redirect is dropped.
    function automatic lc3b_word align_word(input lc3b_word a);
        return a & 16'hFFFE;
    endfunction

endpackage

// File: rtl/lc3b_fetch_buf.sv
// lc3b_fetch_buf: one-entry holding buffer for a word fetched ahead of decode.
// Only instantiated when LC3B_FETCH_PREFETCH_EN is defined.
module lc3b_fetch_buf
    import lc3b_types::*;
(
    input  logic     i_clk,
    input  logic     i_reset,
    input  logic     i_load,
    input  logic     i_clear,
    input  lc3b_word i_data,
    input  lc3b_word i_pc,
    output logic     o_full,
    output lc3b_word o_data,
    output lc3b_word o_pc
);

    logic     r_full;
    lc3b_word r_data;
    lc3b_word r_pc;

    // Occupancy flag; a clear (redirect or drain) wins over a same-cycle load.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
        end
    end

    // Captured word and its byte address.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data <= '0;
            r_pc   <= '0;
        end else if (i_load && !i_clear) begin
            r_data <= i_data;
            r_pc   <= i_pc;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;
    assign o_pc   = r_pc;

endmodule

// File: rtl/lc3b_fetch.sv
// lc3b_fetch: LC-3b instruction fetch unit with branch redirect and decode stall.
// Build option: define LC3B_FETCH_PREFETCH_EN to keep fetching while decode holds
// an instruction, parking one extra word in lc3b_fetch_buf.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  S_REQ   | read request at r_pc is on the bus (mem_read=1)
//  S_HOLD  | no request; waiting for decode to take ir (or drain the buffer)
//  S_FLUSH | stale request still on the bus; its response will be dropped,
//          | then r_redirect is requested
module lc3b_fetch
    import lc3b_types::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
) (
    input  logic       clk,
    input  logic       reset,
    output logic       mem_read,
    output lc3b_word   mem_address,
    input  logic       mem_resp,
    input  lc3b_word   mem_rdata,
    input  logic       stall,
    input  logic       br_taken,
    input  lc3b_word   br_target,
    output logic       ir_valid,
    output lc3b_word   ir,
    output lc3b_opcode opcode,
    output lc3b_word   pc_out
);

    localparam lc3b_word START_PC = align_word(RESET_PC);

    lc3b_fetch_state r_state;
    lc3b_fetch_state w_next_state;

    lc3b_word r_pc;
    lc3b_word r_redirect;
    lc3b_word r_ir;
    lc3b_word r_pc_out;
    logic     r_ir_valid;

    logic     w_req_active;
    logic     w_xfer;
    logic     w_resp_take;
    logic     w_park_on_resp;
    lc3b_word w_target;

    // The bus carries a request in S_REQ and S_FLUSH; S_FLUSH keeps the old
    // address up so a request is never withdrawn before its response.
    assign w_req_active = (r_state == S_REQ) || (r_state == S_FLUSH);
    assign w_xfer       = r_ir_valid && !stall;
    assign w_resp_take  = (r_state == S_REQ) && mem_resp && !br_taken;
    assign w_target     = align_word(br_target);

`ifdef LC3B_FETCH_PREFETCH_EN
    logic     w_buf_load;
    logic     w_buf_clear;
    logic     w_buf_full;
    lc3b_word w_buf_data;
    lc3b_word w_buf_pc;

    // A word arriving while decode is stalled on ir has nowhere else to go.
    assign w_buf_load     = w_resp_take && r_ir_valid && stall;
    assign w_buf_clear    = br_taken || (w_xfer && w_buf_full);
    // Park (stop requesting) only once the buffer is about to fill.
    assign w_park_on_resp = r_ir_valid && stall;

    lc3b_fetch_buf u_buf (
        .i_clk   (clk),
        .i_reset (reset),
        .i_load  (w_buf_load),
        .i_clear (w_buf_clear),
        .i_data  (mem_rdata),
        .i_pc    (r_pc),
        .o_full  (w_buf_full),
        .o_data  (w_buf_data),
        .o_pc    (w_buf_pc)
    );
`else
    // Without prefetch every accepted word parks until decode takes it.
    assign w_park_on_resp = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; br_taken outranks both stall and a delivered word.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_REQ: begin
                if (br_taken) begin
                    w_next_state = mem_resp ? S_REQ : S_FLUSH;
                end else if (mem_resp) begin
                    w_next_state = w_park_on_resp ? S_HOLD : S_REQ;
                end
            end
            S_HOLD: begin
                if (br_taken || w_xfer) begin
                    w_next_state = S_REQ;
                end
            end
            S_FLUSH: begin
                if (mem_resp) begin
                    w_next_state = S_REQ;
                end
            end
            default: w_next_state = S_REQ;
        endcase
    end

    // Outputs; everything is forced quiet while reset is held.
    always_comb begin
        mem_read    = w_req_active && !reset;
        mem_address = r_pc;
        ir_valid    = r_ir_valid && !reset;
        ir          = reset ? '0 : r_ir;
        pc_out      = reset ? '0 : r_pc_out;
        opcode      = reset ? '0 : r_ir[15:12];
    end

    // Fetch PC and pending redirect target. A redirect that lands while a
    // request is still unanswered is parked in r_redirect so mem_address holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= START_PC;
            r_redirect <= '0;
        end else if (br_taken) begin
            if (w_req_active && !mem_resp) begin
                r_redirect <= w_target;
            end else begin
                r_pc <= w_target;
            end
        end else if (mem_resp && (r_state == S_FLUSH)) begin
            r_pc <= r_redirect;
        end else if (mem_resp && (r_state == S_REQ)) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

`ifdef LC3B_FETCH_PREFETCH_EN
    // Instruction register: refilled from the buffer first, then from the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir       <= '0;
            r_pc_out   <= '0;
            r_ir_valid <= 1'b0;
        end else if (br_taken) begin
            r_ir_valid <= 1'b0;
        end else if (w_xfer && w_buf_full) begin
            r_ir       <= w_buf_data;
            r_pc_out   <= w_buf_pc;
            r_ir_valid <= 1'b1;
        end else if (w_resp_take && (!r_ir_valid || w_xfer)) begin
            r_ir       <= mem_rdata;
            r_pc_out   <= r_pc;
            r_ir_valid <= 1'b1;
        end else if (w_xfer) begin
            r_ir_valid <= 1'b0;
        end
    end
`else
    // Instruction register: loaded from the bus, emptied by a transfer or redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir       <= '0;
            r_pc_out   <= '0;
            r_ir_valid <= 1'b0;
        end else if (br_taken) begin
            r_ir_valid <= 1'b0;
        end else if (w_resp_take) begin
            r_ir       <= mem_rdata;
            r_pc_out   <= r_pc;
            r_ir_valid <= 1'b1;
        end else if (w_xfer) begin
            r_ir_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_lc3b_fetch.sv
// tb_lc3b_fetch: directed vector bench for lc3b_fetch (RESET_PC = 0).
// Build option LC3B_FETCH_PREFETCH_EN selects the prefetch scenario instead of
// the cycle table, whose request pattern assumes no prefetch.
module tb_lc3b_fetch;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic [15:0] mem_address;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_target;
    logic        ir_valid;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [15:0] pc_out;

    int n_checks = 0;
    int n_errors = 0;

    lc3b_fetch #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_read    (mem_read),
        .mem_address (mem_address),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .ir_valid    (ir_valid),
        .ir          (ir),
        .opcode      (opcode),
        .pc_out      (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        resp;
        logic [15:0] rdata;
        logic        st;
        logic        br;
        logic [15:0] tgt;
        logic        e_rd;
        logic [15:0] e_addr;
        logic        e_v;
        logic [15:0] e_ir;
        logic [15:0] e_pc;
    } vec_t;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; outputs settle by #1.
    task automatic drive(input logic r, input logic rs, input logic [15:0] rd,
                         input logic st, input logic b, input logic [15:0] t);
        @(negedge clk);
        reset     = r;
        mem_resp  = rs;
        mem_rdata = rd;
        stall     = st;
        br_taken  = b;
        br_target = t;
        #1;
    endtask

    task automatic chk_out(input string nm, input logic e_rd, input logic [15:0] e_addr,
                           input logic e_v, input logic [15:0] e_ir, input logic [15:0] e_pc);
        logic [15:0] e_op;
        e_op = {12'h000, e_ir[15:12]};
        chk({nm, "_rd"}, {15'h0, mem_read}, {15'h0, e_rd});
        if (e_rd) chk({nm, "_addr"}, mem_address, e_addr);
        chk({nm, "_v"}, {15'h0, ir_valid}, {15'h0, e_v});
        chk({nm, "_ir"}, ir, e_ir);
        chk({nm, "_pc"}, pc_out, e_pc);
        chk({nm, "_op"}, {12'h000, opcode}, e_op);
    endtask

`ifdef LC3B_FETCH_PREFETCH_EN
    int lat = 0;

    // Three-cycle memory: a response on the third cycle a request is seen.
    task automatic mem_step(input logic st);
        @(negedge clk);
        reset     = 1'b0;
        stall     = st;
        br_taken  = 1'b0;
        br_target = 16'h0000;
        mem_resp  = 1'b0;
        #1;
        if (mem_read) begin
            lat++;
            if (lat == 3) begin
                mem_resp  = 1'b1;
                mem_rdata = mem_address ^ 16'h1021;
                lat       = 0;
            end
        end
    endtask
`endif

    initial begin
        vec_t vecs [24];
        reset = 1'b1; mem_resp = 1'b0; mem_rdata = '0;
        stall = 1'b0; br_taken = 1'b0; br_target = '0;

`ifndef LC3B_FETCH_PREFETCH_EN
        //           rst resp rdata    st br tgt       e_rd e_addr   e_v e_ir     e_pc
        vecs[0]  = '{1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000};
        vecs[1]  = '{1, 1, 16'hABCD, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000};
        vecs[2]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000};
        vecs[3]  = '{0, 1, 16'h1021, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000};
        vecs[4]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h1021, 16'h0000};
        vecs[5]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 0, 16'h1021, 16'h0000};
        vecs[6]  = '{0, 1, 16'h5A5A, 0, 0, 16'h0000, 1, 16'h0002, 0, 16'h1021, 16'h0000};
        vecs[7]  = '{0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h5A5A, 16'h0002};
        vecs[8]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h5A5A, 16'h0002};
        vecs[9]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0004, 0, 16'h5A5A, 16'h0002};
        vecs[10] = '{0, 0, 16'h0000, 0, 1, 16'h3001, 1, 16'h0004, 0, 16'h5A5A, 16'h0002};
        vecs[11] = '{0, 1, 16'hDEAD, 0, 0, 16'h0000, 1, 16'h0004, 0, 16'h5A5A, 16'h0002};
        vecs[12] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h3000, 0, 16'h5A5A, 16'h0002};
        vecs[13] = '{0, 1, 16'hE0F0, 0, 0, 16'h0000, 1, 16'h3000, 0, 16'h5A5A, 16'h0002};
        vecs[14] = '{0, 0, 16'h0000, 1, 1, 16'h4000, 0, 16'h0000, 1, 16'hE0F0, 16'h3000};
        vecs[15] = '{0, 1, 16'hBEEF, 0, 1, 16'h5000, 1, 16'h4000, 0, 16'hE0F0, 16'h3000};
        vecs[16] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h5000, 0, 16'hE0F0, 16'h3000};
        vecs[17] = '{0, 1, 16'h1234, 0, 0, 16'h0000, 1, 16'h5000, 0, 16'hE0F0, 16'h3000};
        vecs[18] = '{0, 0, 16'h0000, 0, 1, 16'h6000, 0, 16'h0000, 1, 16'h1234, 16'h5000};
        vecs[19] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h6000, 0, 16'h1234, 16'h5000};
        vecs[20] = '{1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000};
        vecs[21] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000};
        vecs[22] = '{0, 1, 16'h7777, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000};
        vecs[23] = '{0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h7777, 16'h0000};

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].rst, vecs[i].resp, vecs[i].rdata, vecs[i].st, vecs[i].br, vecs[i].tgt);
            chk_out($sformatf("row%0d", i), vecs[i].e_rd, vecs[i].e_addr,
                    vecs[i].e_v, vecs[i].e_ir, vecs[i].e_pc);
        end

        // Long stall: ir held, no request issued.
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 16'h0000, 1, 0, 16'h0000);
            chk_out($sformatf("stall%0d", k), 1'b0, 16'h0000, 1'b1, 16'h7777, 16'h0000);
        end
        drive(0, 0, 16'h0000, 0, 0, 16'h0000);
        chk_out("release", 1'b0, 16'h0000, 1'b1, 16'h7777, 16'h0000);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000);
        chk_out("next_req", 1'b1, 16'h0002, 1'b0, 16'h7777, 16'h0000);

        // Wrap: redirect to odd 0xFFFF during an outstanding read, then fetch 0xFFFE.
        drive(0, 0, 16'h0000, 0, 1, 16'hFFFF);
        chk_out("wrap_br", 1'b1, 16'h0002, 1'b0, 16'h7777, 16'h0000);
        drive(0, 1, 16'hAAAA, 0, 0, 16'h0000);
        chk_out("wrap_drop", 1'b1, 16'h0002, 1'b0, 16'h7777, 16'h0000);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000);
        chk_out("wrap_req", 1'b1, 16'hFFFE, 1'b0, 16'h7777, 16'h0000);
        drive(0, 1, 16'h0F0F, 0, 0, 16'h0000);
        chk_out("wrap_resp", 1'b1, 16'hFFFE, 1'b0, 16'h7777, 16'h0000);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000);
        chk_out("wrap_ir", 1'b0, 16'h0000, 1'b1, 16'h0F0F, 16'hFFFE);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000);
        chk_out("wrap_next", 1'b1, 16'h0000, 1'b0, 16'h0F0F, 16'hFFFE);
`else
        begin
            logic        seen;
            logic [15:0] first_pc;
            drive(1, 0, 16'h0000, 0, 0, 16'h0000);
            chk_out("rst0", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
            drive(1, 0, 16'h0000, 0, 0, 16'h0000);
            chk_out("rst1", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);

            // Hold stall high from the start; it only matters once ir_valid rises.
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                mem_step(1'b1);
                seen = ir_valid;
            end
            chk("wait_ir_valid", {15'h0, seen}, 16'h0001);
            chk_out("pf_stall0", mem_read, mem_address, 1'b1, 16'h1021, 16'h0000);
            for (int k = 1; k < 6; k++) begin
                mem_step(1'b1);
                chk_out($sformatf("pf_stall%0d", k), mem_read, mem_address,
                        1'b1, 16'h1021, 16'h0000);
            end
            chk("pf_buf_full_noread", {15'h0, mem_read}, 16'h0000);

            mem_step(1'b0);
            chk("pf_xfer0_v", {15'h0, ir_valid}, 16'h0001);
            first_pc = pc_out;
            chk("pf_xfer0_pc", first_pc, 16'h0000);
            mem_step(1'b0);
            chk("pf_xfer1_v", {15'h0, ir_valid}, 16'h0001);
            chk("pf_xfer1_pc", pc_out, 16'h0002);
            chk("pf_xfer1_ir", ir, 16'h1023);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lc3b_fetch.md
LC3B_FETCH -- requirements
Module: lc3b_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  rising-edge clock, the single clock of the block.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port mem_read  out  1  instruction memory read request.
REQ-005 SHALL have port mem_address  out  16  byte address of the request.
REQ-006 SHALL have port mem_resp  in  1  one-cycle read-complete strobe.
REQ-007 SHALL have port mem_rdata  in  16  instruction word, valid with mem_resp.
REQ-008 SHALL have port stall  in  1  decode not ready to accept.
REQ-009 SHALL have port br_taken  in  1  one-cycle redirect strobe.
REQ-010 SHALL have port br_target  in  16  redirect byte address.
REQ-011 SHALL have port ir_valid  out  1  ir/opcode/pc_out hold a deliverable instruction.
REQ-012 SHALL have port ir  out  16  instruction word (lc3b_word).
REQ-013 SHALL have port opcode  out  4  ir[15:12] as lc3b_opcode, feeding control_rom.
REQ-014 SHALL have port pc_out  out  16  byte address of the instruction in ir.

Function
REQ-015 SHALL implement states S_REQ (mem_read=1), S_HOLD (ir_valid=1, no request) and S_FLUSH (request outstanding, response to be discarded).
REQ-016 SHALL, once mem_read rises, hold mem_read and mem_address stable until the cycle mem_resp=1 (requests are never withdrawn, except by reset).
REQ-017 SHALL, on mem_resp in S_REQ in cycle N, load ir<=mem_rdata and pc_out<=mem_address, assert ir_valid in N+1, and advance PC by 2.
REQ-018 SHALL treat a cycle with ir_valid=1 and stall=0 as a transfer; ir, pc_out and ir_valid SHALL not change while ir_valid=1 and stall=1.
REQ-019 SHALL, after a transfer with no buffered word, deassert ir_valid and assert mem_read at the next PC in the following cycle.
REQ-020 SHALL wrap PC from 16'hFFFE to 16'h0000 without error.
REQ-021 SHALL force bit 0 of br_target and of RESET_PC to 0.
REQ-022 SHALL, on br_taken, clear ir_valid next cycle, discard any buffered word, and load PC<=br_target.
REQ-023 SHALL, on br_taken while a request is outstanding and mem_resp=0, go to S_FLUSH, drop that response, then request br_target.
REQ-024 SHALL, on br_taken and mem_resp in the same cycle, discard mem_rdata and assert mem_read at br_target in the next cycle.
REQ-025 SHALL, on br_taken coincident with a transfer, still complete the transfer (the consumer owns it) and then redirect.
REQ-026 SHALL give br_taken priority over stall.

Reset
REQ-027 SHALL, while reset=1, drive mem_read=0, ir_valid=0, ir=16'h0000, pc_out=16'h0000, PC=RESET_PC, state S_REQ, and clear the buffer and squash flag.
REQ-028 SHALL abandon an outstanding request on reset; a late mem_resp after reset SHALL be ignored until the first post-reset request is issued.
REQ-029 SHALL assert mem_read at RESET_PC in the first cycle after reset falls.

Configuration
REQ-030 SHALL, with LC3B_FETCH_PREFETCH_EN defined, keep issuing the next request while in S_HOLD, capturing one word in a one-entry buffer; a transfer then loads ir from the buffer with ir_valid staying 1, and no request issues while the buffer is full.
REQ-031 SHALL, without LC3B_FETCH_PREFETCH_EN, issue no request while ir_valid=1, and include no buffer logic.

Structure
REQ-032 SHALL place lc3b_word, lc3b_opcode and the fetch state enum lc3b_fetch_state in package lc3b_types.
REQ-033 SHALL implement the prefetch buffer as sub-module lc3b_fetch_buf (load, clear, full, data, pc).

Verification
REQ-034 SHALL check reset release with RESET_PC=16'h0000 and a 1-cycle memory: mem_read=1 at 16'h0000; mem_rdata=16'h1021 gives ir_valid=1, opcode=4'b0001, pc_out=16'h0000.
REQ-035 SHALL check stall=1 held for 5 cycles: ir, pc_out and ir_valid are unchanged; without the macro, mem_read=0 throughout.
REQ-036 SHALL check br_taken with br_target=16'h3001 while a read of 16'h0004 is outstanding: that response is dropped and the next request is at 16'h3000.
REQ-037 SHALL check br_taken and mem_resp in the same cycle: the word is not delivered and mem_read is at br_target in the next cycle.
REQ-038 SHALL check wrap-around with PC=16'hFFFE: the next request is at 16'h0000.
REQ-039 SHALL check the macro build with 3-cycle memory and stall for 6 cycles: the buffer fills, mem_read drops, and on release back-to-back ir_valid transfers occur with consecutive pc_out values.
